// File: rtl/ff_excitation_driver_pkg.sv
// Shared encodings for the flip-flop excitation driver: flip-flop type selects
// and the transaction FSM states.
package ff_excitation_driver_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_SR = 2'd0;
    localparam logic [MODE_W-1:0] MODE_JK = 2'd1;
    localparam logic [MODE_W-1:0] MODE_D  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_T  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXCITE = 2'd1,
        VERIFY = 2'd2
    } state_e;

endpackage

// File: rtl/ff_core.sv
// One-bit universal flip-flop: applies the characteristic equation of the
// selected flip-flop type when enabled.
module ff_core
    import ff_excitation_driver_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              en_i,
    input  logic              s_i,
    input  logic              r_i,
    input  logic              j_i,
    input  logic              k_i,
    input  logic              d_i,
    input  logic              t_i,
    output logic              q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case (mode_i)
            MODE_SR: q_d = s_i | (~r_i & q_q);
            MODE_JK: q_d = (j_i & ~q_q) | (~k_i & q_q);
            MODE_D:  q_d = d_i;
            default: q_d = t_i ^ q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else if (en_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ff_excitation_driver.sv
// Maps a requested next state to SR/JK/D/T excitations, drives a per-bit
// flip-flop core with the selected one and checks that the core reached it.
module ff_excitation_driver
    import ff_excitation_driver_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  target_i,
    input  logic              inject_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [WIDTH-1:0]  s_o,
    output logic [WIDTH-1:0]  r_o,
    output logic [WIDTH-1:0]  j_o,
    output logic [WIDTH-1:0]  k_o,
    output logic [WIDTH-1:0]  d_o,
    output logic [WIDTH-1:0]  t_o,
    output logic [WIDTH-1:0]  q_o,
    output logic              out_valid_o,
    output logic              match_o,
    output logic [CNT_W-1:0]  mismatch_cnt_o
);

    state_e            state_q;
    logic              ready_q;
    logic [MODE_W-1:0] mode_q;
    logic [WIDTH-1:0]  target_q;
    logic              inject_q;
    logic [WIDTH-1:0]  s_q, r_q, j_q, k_q, d_q, t_q;
    logic              out_valid_q;
    logic              match_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [WIDTH-1:0]  q_w;
    logic [WIDTH-1:0]  s_d, r_d, j_d, k_d, d_d, t_d;
    logic [WIDTH-1:0]  inj_mask;
    logic              excite_c;

    // Excitation tables with don't-cares resolved to 0, so S=R=1 never appears.
    always_comb begin
        s_d      = ~q_w & target_q;
        r_d      = q_w & ~target_q;
        j_d      = ~q_w & target_q;
        k_d      = q_w & ~target_q;
        d_d      = target_q;
        t_d      = q_w ^ target_q;
        inj_mask = WIDTH'(inject_q);
    end

    assign excite_c = (state_q == EXCITE);

    // Injection corrupts only what the core sees; the published excitations stay clean.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        ff_core u_core (
            .clk    (clk),
            .rst_n  (rst_n),
            .mode_i (mode_q),
            .en_i   (excite_c),
            .s_i    (s_d[b] ^ inj_mask[b]),
            .r_i    (r_d[b]),
            .j_i    (j_d[b] ^ inj_mask[b]),
            .k_i    (k_d[b]),
            .d_i    (d_d[b] ^ inj_mask[b]),
            .t_i    (t_d[b] ^ inj_mask[b]),
            .q_o    (q_w[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            mode_q      <= MODE_SR;
            target_q    <= '0;
            inject_q    <= 1'b0;
            s_q         <= '0;
            r_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            d_q         <= '0;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            match_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (in_valid_i && ready_q) begin
                        mode_q   <= mode_i;
                        target_q <= target_i;
                        inject_q <= inject_i;
                        ready_q  <= 1'b0;
                        state_q  <= EXCITE;
                    end
                end
                EXCITE: begin
                    s_q     <= s_d;
                    r_q     <= r_d;
                    j_q     <= j_d;
                    k_q     <= k_d;
                    d_q     <= d_d;
                    t_q     <= t_d;
                    state_q <= VERIFY;
                end
                VERIFY: begin
                    out_valid_q <= 1'b1;
                    match_q     <= (q_w == target_q);
                    if ((q_w != target_q) && !(&cnt_q)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o     = ready_q;
    assign s_o            = s_q;
    assign r_o            = r_q;
    assign j_o            = j_q;
    assign k_o            = k_q;
    assign d_o            = d_q;
    assign t_o            = t_q;
    assign q_o            = q_w;
    assign out_valid_o    = out_valid_q;
    assign match_o        = match_q;
    assign mismatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Randomized self-checking bench for ff_excitation_driver against a
// transaction-level excitation-table model.
module tb_ff_excitation_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] target;
    logic       inject;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] s, r, j, k, d, t, q;
    logic       out_valid;
    logic       match;
    logic [7:0] mismatch_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0] q_m;
    int         cnt_m;

    // Excitation tables indexed by {present, next}: 00, 01, 10, 11.
    logic tbl_set [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic tbl_rst [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    ff_excitation_driver #(.WIDTH(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode_i         (mode),
        .target_i       (target),
        .inject_i       (inject),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .s_o            (s),
        .r_o            (r),
        .j_o            (j),
        .k_o            (k),
        .d_o            (d),
        .t_o            (t),
        .q_o            (q),
        .out_valid_o    (out_valid),
        .match_o        (match),
        .mismatch_cnt_o (mismatch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic run_txn(input logic [1:0] m, input logic [3:0] tg, input logic inj);
        logic [3:0] e_s, e_r, e_d, e_t, e_q, qs;
        int n;
        qs = q_m;
        n  = 0;
        while (in_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_wait", 32'(in_ready), 32'd1);
        mode     = m;
        target   = tg;
        inject   = inj;
        in_valid = 1'b1;
        @(negedge clk);
        // Inputs outside IDLE must be ignored.
        in_valid = 1'b0;
        mode     = 2'($urandom);
        target   = 4'($urandom);
        inject   = 1'($urandom);
        for (int b = 0; b < 4; b++) begin
            e_s[b] = tbl_set[{qs[b], tg[b]}];
            e_r[b] = tbl_rst[{qs[b], tg[b]}];
        end
        e_d = tg;
        e_t = qs ^ tg;
        e_q = tg;
        if (inj) begin
            case (m)
                2'd0:    e_q[0] = ~e_s[0] | (~e_r[0] & qs[0]);
                2'd1:    e_q[0] = (~e_s[0] & ~qs[0]) | (~e_r[0] & qs[0]);
                2'd2:    e_q[0] = ~e_d[0];
                default: e_q[0] = ~e_t[0] ^ qs[0];
            endcase
        end
        @(negedge clk);
        check_val("busy_ready", 32'(in_ready), 32'd0);
        check_val("early_valid", 32'(out_valid), 32'd0);
        check_val("q", 32'(q), 32'(e_q));
        check_val("s", 32'(s), 32'(e_s));
        check_val("r", 32'(r), 32'(e_r));
        check_val("j", 32'(j), 32'(e_s));
        check_val("k", 32'(k), 32'(e_r));
        check_val("d", 32'(d), 32'(e_d));
        check_val("t", 32'(t), 32'(e_t));
        check_val("s_and_r", 32'(s & r), 32'd0);
        @(negedge clk);
        if (e_q != tg && cnt_m < 255) cnt_m++;
        check_val("out_valid", 32'(out_valid), 32'd1);
        check_val("match", 32'(match), 32'(e_q == tg));
        check_val("cnt", 32'(mismatch_cnt), 32'(cnt_m));
        check_val("q_hold", 32'(q), 32'(e_q));
        q_m = e_q;
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'd0; target = 4'd0; inject = 1'b0; in_valid = 1'b0;
        q_m = 4'd0; cnt_m = 0;
        repeat (2) @(negedge clk);
        check_val("rst_ready", 32'(in_ready), 32'd0);
        check_val("rst_q", 32'(q), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_cnt", 32'(mismatch_cnt), 32'd0);
        check_val("rst_exc", 32'({s, r, j, k, d, t}), 32'd0);
        rst_n = 1'b1;

        run_txn(2'd0, 4'b1010, 1'b0);
        check_val("sr_s", 32'(s), 32'b1010);
        run_txn(2'd1, 4'b0110, 1'b0);
        check_val("jk_j", 32'(j), 32'b0100);
        check_val("jk_k", 32'(k), 32'b1000);

        // Back-to-back requests: ready only every third cycle.
        mode = 2'd3; target = q_m; inject = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_val("tput_ready", 32'(in_ready), 32'(i % 3 == 0));
            check_val("tput_valid", 32'(out_valid), 32'(i % 3 == 0));
            if (i > 0 && out_valid) check_val("tput_match", 32'(match), 32'd1);
            if (i == 8) in_valid = 1'b0;
            @(negedge clk);
        end
        check_val("tput_q", 32'(q), 32'(q_m));
        check_val("tput_t", 32'(t), 32'd0);

        run_txn(2'd2, 4'b1111, 1'b1);
        check_val("inj_q", 32'(q), 32'b1110);
        check_val("inj_cnt", 32'(mismatch_cnt), 32'd1);
        for (int i = 1; i < 300; i++) run_txn(2'd2, 4'b1111, 1'b1);
        check_val("sat_cnt", 32'(mismatch_cnt), 32'd255);

        // Reset in the middle of EXCITE aborts the transaction.
        mode = 2'd0; target = 4'b0101; inject = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("abort_q", 32'(q), 32'd0);
        check_val("abort_cnt", 32'(mismatch_cnt), 32'd0);
        check_val("abort_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q_m = 4'd0; cnt_m = 0;
        @(negedge clk);
        check_val("abort_ready_rel", 32'(in_ready), 32'd1);
        check_val("abort_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_val("abort_valid2", 32'(out_valid), 32'd0);
        check_val("abort_q2", 32'(q), 32'd0);

        for (int m = 0; m < 4; m++)
            for (int qs = 0; qs < 16; qs++)
                for (int tg = 0; tg < 16; tg++) begin
                    run_txn(2'd2, 4'(qs), 1'b0);
                    run_txn(2'(m), 4'(tg), 1'b0);
                end

        for (int i = 0; i < 300; i++)
            run_txn(2'($urandom), 4'($urandom), $urandom_range(0, 3) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ff_excitation_driver.md
Name: ff_excitation_driver

Overview:
- Inverse of the flip-flop conversion blocks: a conversion block maps excitation inputs to a next state; this block maps a requested next state back to the excitation inputs for a chosen flip-flop type.
- For each accepted WIDTH-bit target, it derives SR, JK, D and T excitations from the current state and the target, then applies the selected excitation to an internal per-bit flip-flop core.
- It then verifies that q reached the target.
- Used as a self-checking stimulus source and excitation-table reference for the flip-flop conversion family.

Parameters:
- WIDTH, 4: number of flip-flop bits driven in parallel.
- CNT_W, 8: width of the saturating mismatch counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  2  flip-flop type for the transaction: 0=SR, 1=JK, 2=D, 3=T; sampled at accept
- target  input  WIDTH  requested next state; sampled at accept
- inject  input  1  error injection; sampled at accept; inverts the bit-0 excitation applied to the core
- in_valid  input  1  target/mode valid
- in_ready  output  1  block can accept a target
- s, r  output  WIDTH  SR excitation
- j, k  output  WIDTH  JK excitation
- d  output  WIDTH  D excitation
- t  output  WIDTH  T excitation
- q  output  WIDTH  flip-flop core state
- out_valid  output  1  one-cycle pulse when the verify result is available
- match  output  1  q==target for the current result; valid only while out_valid=1
- mismatch_cnt  output  CNT_W  saturating count of failed transactions

Behaviour:
- Reset (async, rst_n=0): state=IDLE; q, s, r, j, k, d, t, out_valid, match, mismatch_cnt all 0; in_ready=0 while rst_n=0.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready; latch target, mode and inject; go to EXCITE.
- EXCITE (one cycle):
  - in_ready=0. All excitation outputs are registered, computed from current q and the latched target, per bit.
  - SR: 0->0 S0 R0; 0->1 S1 R0; 1->0 S0 R1; 1->1 S0 R0.
  - JK: 0->0 J0 K0; 0->1 J1 K0; 1->0 J0 K1; 1->1 J0 K0. Don't-cares are always resolved to 0.
  - d = target; t = q ^ target.
  - S=R=1 is never generated.
  - At the end of the cycle the core updates q from the mode-selected excitation using the characteristic equation:
    - SR: q' = S | (~R & q)
    - JK: q' = (J & ~q) | (~K & q)
    - D: q' = D
    - T: q' = T ^ q
  - If inject=1, the bit-0 excitation fed to the core (S for SR, J for JK, D for D, T for T) is inverted. Outputs s/j/d/t still show the uninverted values.
- VERIFY (one cycle):
  - out_valid=1; match=(q==target).
  - If match=0, mismatch_cnt increments and holds at all-ones (saturates).
  - Next state is IDLE.
- Throughput is one transaction per 3 cycles. Latency from accept edge to out_valid is 2 cycles.
- Excitation outputs hold their values until the next EXCITE.
- Changes to mode, target or inject while not in IDLE are ignored.
- Target equal to current q is legal: all excitations are 0 except d=q; match=1.
- Reset asserted in EXCITE or VERIFY aborts the transaction immediately. No out_valid is produced and there is no count update.

Decomposition:
- Shared package:
  - mode encodings MODE_SR=2'd0, MODE_JK=2'd1, MODE_D=2'd2, MODE_T=2'd3;
  - FSM state encodings IDLE, EXCITE, VERIFY.
- Sub-module ff_core:
  - one-bit universal flip-flop with clk, rst_n, mode, enable and the four excitations;
  - evaluates the characteristic equation above;
  - instantiated WIDTH times.
- The top level holds the FSM, the excitation table logic and the counter.

Test Plan:
- Reset, then mode=SR, target=4'b1010 from q=0000 -> s=1010, r=0000, q=1010 two cycles after accept, match=1, mismatch_cnt=0.
- From q=1010, mode=JK, target=4'b0110 -> j=0100, k=1000, t=1100, d=0110, q=0110, match=1.
- mode=T, target=q=0110 -> t=0000, s=r=j=k=0000, q unchanged, match=1; in_valid held high sees in_ready=1 only every third cycle.
- mode=D, inject=1, target=4'b1111 from q=0110 -> q=1110, match=0, mismatch_cnt=1. Repeated 300 times with CNT_W=8 -> counter saturates at 255.
- rst_n pulled low during EXCITE -> q=0000, no out_valid pulse, mismatch_cnt=0, in_ready=1 one cycle after release.
- Across all modes and 16x16 (q,target) pairs -> r&s is never 1, and match=1 whenever inject=0.
